// File: rtl/eth_phy_pkg.sv
// Shared types and byte constants for the GMII PHY loopback endpoint.
// Ports: none (package only).
package eth_phy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_DROP     = 2'd3
    } phy_state_t;

    localparam logic [7:0] ETH_PRE   = 8'h55;
    localparam logic [7:0] ETH_SFD   = 8'hD5;
    localparam logic [7:0] GMII_IDLE = 8'h00;

endpackage

// File: rtl/gmii_delay_line.sv
// Fixed-depth shift register carrying the {en,er,d} GMII bundle.
// Ports: clk, rst_n, d_i (WIDTH) in; q_o (WIDTH) out. DEPTH=0 is a wire.
module gmii_delay_line #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (DEPTH == 0) begin : g_wire
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;
        assign q_o = d_i;
    end else begin : g_sr
        logic [WIDTH-1:0] sr_q [DEPTH];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < DEPTH; i++) begin
                    sr_q[i] <= '0;
                end
            end else begin
                sr_q[0] <= d_i;
                for (int i = 1; i < DEPTH; i++) begin
                    sr_q[i] <= sr_q[i-1];
                end
            end
        end

        assign q_o = sr_q[DEPTH-1];
    end

endmodule

// File: rtl/gmii_phy_loopback.sv
// GMII PHY stand-in: replays MAC TX on MAC RX with fixed latency, optional
// preamble trim, link-down handling, single-shot error injection, stats.
// Ports: clk, rst_n; gmii_tx* in; gmii_rx* out; cfg_* in; stat_* out.
module gmii_phy_loopback
    import eth_phy_pkg::*;
#(
    parameter int LATENCY       = 4,
    parameter int PREAMBLE_TRIM = 0,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           gmii_txd,
    input  logic                 gmii_tx_en,
    input  logic                 gmii_tx_er,
    output logic [7:0]           gmii_rxd,
    output logic                 gmii_rx_dv,
    output logic                 gmii_rx_er,
    input  logic                 cfg_link_up,
    input  logic                 cfg_err_inject,
    input  logic [10:0]          cfg_err_offset,
    output logic [CNT_WIDTH-1:0] stat_frame_count,
    output logic [CNT_WIDTH-1:0] stat_byte_count,
    output logic [CNT_WIDTH-1:0] stat_tx_er_count,
    output logic                 stat_err_injected,
    output logic                 stat_frame_drop
);

    localparam logic [2:0] TRIM_MAX = 3'(PREAMBLE_TRIM);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    phy_state_t           state_q, state_d;
    logic [2:0]           trim_cnt_q, trim_cnt_d;
    logic [10:0]          byte_idx_q, byte_idx_d;
    logic [10:0]          off_q, off_d;
    logic                 armed_q, armed_d;
    logic                 txer_flag_q, txer_flag_d;
    logic [9:0]           stage_q;
    logic                 inj_q, drop_q;
    logic [CNT_WIDTH-1:0] frame_cnt_q, byte_cnt_q, txer_cnt_q;
    logic [9:0]           dly_q;

    logic       en_c, er_c;
    logic [7:0] d_c;
    logic       inj_c, drop_c, frame_end_c, data_byte_c, clr_arm_c;
    logic       first_c, pre_c;
    logic [2:0] trim_base_c;

    always_comb begin
        state_d     = state_q;
        trim_cnt_d  = trim_cnt_q;
        byte_idx_d  = byte_idx_q;
        off_d       = off_q;
        txer_flag_d = txer_flag_q;
        en_c        = 1'b0;
        er_c        = 1'b0;
        d_c         = GMII_IDLE;
        inj_c       = 1'b0;
        drop_c      = 1'b0;
        frame_end_c = 1'b0;
        data_byte_c = 1'b0;
        clr_arm_c   = 1'b0;

        // The rising byte is handled as a preamble byte in the same cycle.
        first_c     = (state_q == ST_IDLE) && gmii_tx_en && cfg_link_up;
        pre_c       = first_c || ((state_q == ST_PREAMBLE) && gmii_tx_en);
        trim_base_c = first_c ? 3'd0 : trim_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (gmii_tx_en && !cfg_link_up) begin
                    state_d = ST_DROP;
                    drop_c  = 1'b1;
                end
            end
            ST_PREAMBLE: begin
                if (!gmii_tx_en) begin
                    state_d     = ST_IDLE;
                    frame_end_c = 1'b1;
                end
            end
            ST_DATA: begin
                if (gmii_tx_en) begin
                    en_c        = 1'b1;
                    d_c         = gmii_txd;
                    er_c        = gmii_tx_er | ~cfg_link_up;
                    data_byte_c = 1'b1;
                    txer_flag_d = txer_flag_q | gmii_tx_er;
                    if (~&byte_idx_q) begin
                        byte_idx_d = byte_idx_q + 11'd1;
                    end
                    if (armed_q && (byte_idx_q == off_q)) begin
                        d_c       = gmii_txd ^ 8'h01;
                        er_c      = 1'b1;
                        inj_c     = 1'b1;
                        clr_arm_c = 1'b1;
                    end
                end else begin
                    state_d     = ST_IDLE;
                    frame_end_c = 1'b1;
                    // Disarm only if this frame ran past the target byte.
                    clr_arm_c   = byte_idx_q > off_q;
                end
            end
            ST_DROP: begin
                if (!gmii_tx_en) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (pre_c) begin
            state_d     = ST_PREAMBLE;
            trim_cnt_d  = trim_base_c;
            txer_flag_d = (first_c ? 1'b0 : txer_flag_q) | gmii_tx_er;
            if ((gmii_txd == ETH_PRE) && (trim_base_c < TRIM_MAX)) begin
                trim_cnt_d = trim_base_c + 3'd1;
            end else begin
                en_c = 1'b1;
                d_c  = gmii_txd;
                er_c = gmii_tx_er | ~cfg_link_up;
                if (gmii_txd == ETH_SFD) begin
                    state_d    = ST_DATA;
                    byte_idx_d = '0;
                    off_d      = cfg_err_offset;
                end
            end
        end

        armed_d = clr_arm_c ? 1'b0 : (armed_q | cfg_err_inject);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            trim_cnt_q  <= '0;
            byte_idx_q  <= '0;
            off_q       <= '0;
            armed_q     <= 1'b0;
            txer_flag_q <= 1'b0;
            stage_q     <= '0;
            inj_q       <= 1'b0;
            drop_q      <= 1'b0;
            frame_cnt_q <= '0;
            byte_cnt_q  <= '0;
            txer_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            trim_cnt_q  <= trim_cnt_d;
            byte_idx_q  <= byte_idx_d;
            off_q       <= off_d;
            armed_q     <= armed_d;
            txer_flag_q <= txer_flag_d;
            stage_q     <= {en_c, er_c, d_c};
            inj_q       <= inj_c;
            drop_q      <= drop_c;
            if (frame_end_c && ~&frame_cnt_q) begin
                frame_cnt_q <= frame_cnt_q + CNT_ONE;
            end
            if (frame_end_c && txer_flag_q && ~&txer_cnt_q) begin
                txer_cnt_q <= txer_cnt_q + CNT_ONE;
            end
            if (data_byte_c && ~&byte_cnt_q) begin
                byte_cnt_q <= byte_cnt_q + CNT_ONE;
            end
        end
    end

    gmii_delay_line #(
        .WIDTH(10),
        .DEPTH(LATENCY - 1)
    ) u_delay (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  (stage_q),
        .q_o  (dly_q)
    );

    assign gmii_rx_dv        = dly_q[9];
    assign gmii_rx_er        = dly_q[8];
    assign gmii_rxd          = dly_q[7:0];
    assign stat_frame_count  = frame_cnt_q;
    assign stat_byte_count   = byte_cnt_q;
    assign stat_tx_er_count  = txer_cnt_q;
    assign stat_err_injected = inj_q;
    assign stat_frame_drop   = drop_q;

endmodule

// File: tb/tb_gmii_phy_loopback.sv
// Bench for gmii_phy_loopback: three instances (plain, trimmed, narrow
// counters with latency 1) share one stimulus stream; scoreboard per DUT.
module tb_gmii_phy_loopback;

    typedef struct packed {
        int         cyc;
        logic       er;
        logic [7:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  gmii_txd = 8'h00;
    logic        gmii_tx_en = 1'b0;
    logic        gmii_tx_er = 1'b0;
    logic        cfg_link_up = 1'b1;
    logic        cfg_err_inject = 1'b0;
    logic [10:0] cfg_err_offset = 11'd0;

    logic [7:0]  rxd [3];
    logic        dv  [3];
    logic        rer [3];
    logic        inj [3];
    logic        drp [3];
    logic [31:0] fc_a, bc_a, ec_a, fc_b, bc_b, ec_b;
    logic [3:0]  fc_c, bc_c, ec_c;

    exp_t sbq [3][$];
    exp_t e;
    int   cyc = 0;
    int   vec = 0;
    int   errs = 0;
    bit   mon_en = 1'b0;
    logic link_v = 1'b1;
    int   dv_cnt [3] = '{0, 0, 0};
    int   inj_seen [3] = '{0, 0, 0};
    int   drop_seen [3] = '{0, 0, 0};
    int   exp_frames = 0;
    int   exp_bytes = 0;
    int   exp_txer = 0;

    always #4 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gmii_phy_loopback #(.LATENCY(4), .PREAMBLE_TRIM(0), .CNT_WIDTH(32)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en), .gmii_tx_er(gmii_tx_er),
        .gmii_rxd(rxd[0]), .gmii_rx_dv(dv[0]), .gmii_rx_er(rer[0]),
        .cfg_link_up(cfg_link_up), .cfg_err_inject(cfg_err_inject),
        .cfg_err_offset(cfg_err_offset),
        .stat_frame_count(fc_a), .stat_byte_count(bc_a), .stat_tx_er_count(ec_a),
        .stat_err_injected(inj[0]), .stat_frame_drop(drp[0])
    );

    gmii_phy_loopback #(.LATENCY(4), .PREAMBLE_TRIM(3), .CNT_WIDTH(32)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en), .gmii_tx_er(gmii_tx_er),
        .gmii_rxd(rxd[1]), .gmii_rx_dv(dv[1]), .gmii_rx_er(rer[1]),
        .cfg_link_up(cfg_link_up), .cfg_err_inject(cfg_err_inject),
        .cfg_err_offset(cfg_err_offset),
        .stat_frame_count(fc_b), .stat_byte_count(bc_b), .stat_tx_er_count(ec_b),
        .stat_err_injected(inj[1]), .stat_frame_drop(drp[1])
    );

    gmii_phy_loopback #(.LATENCY(1), .PREAMBLE_TRIM(6), .CNT_WIDTH(4)) dut_c (
        .clk(clk), .rst_n(rst_n),
        .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en), .gmii_tx_er(gmii_tx_er),
        .gmii_rxd(rxd[2]), .gmii_rx_dv(dv[2]), .gmii_rx_er(rer[2]),
        .cfg_link_up(cfg_link_up), .cfg_err_inject(cfg_err_inject),
        .cfg_err_offset(cfg_err_offset),
        .stat_frame_count(fc_c), .stat_byte_count(bc_c), .stat_tx_er_count(ec_c),
        .stat_err_injected(inj[2]), .stat_frame_drop(drp[2])
    );

    function automatic int lat_of(input int k);
        return (k == 2) ? 1 : 4;
    endfunction

    function automatic int trim_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 3 : 6);
    endfunction

    function automatic int sat15(input int x);
        return (x > 15) ? 15 : x;
    endfunction

    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            for (int k = 0; k < 3; k++) begin
                if (inj[k]) inj_seen[k]++;
                if (drp[k]) drop_seen[k]++;
                vec++;
                if (dv[k]) begin
                    dv_cnt[k]++;
                    if (sbq[k].size() == 0) begin
                        errs++;
                        $display("FAIL rx_unexpected dut%0d cyc %0d: got d=%h er=%b, want rx_dv=0",
                                 k, cyc, rxd[k], rer[k]);
                    end else begin
                        e = sbq[k].pop_front();
                        if (e.cyc !== cyc || e.d !== rxd[k] || e.er !== rer[k]) begin
                            errs++;
                            $display("FAIL rx_byte dut%0d: got cyc %0d d=%h er=%b, want cyc %0d d=%h er=%b",
                                     k, cyc, rxd[k], rer[k], e.cyc, e.d, e.er);
                        end
                    end
                end else if (rxd[k] !== 8'h00 || rer[k] !== 1'b0) begin
                    errs++;
                    $display("FAIL rx_idle dut%0d cyc %0d: got d=%h er=%b, want 00/0",
                             k, cyc, rxd[k], rer[k]);
                end
            end
        end
    end

    task automatic drive(input logic en, input logic [7:0] d, input logic er);
        @(negedge clk);
        gmii_tx_en  = en;
        gmii_txd    = d;
        gmii_tx_er  = er;
        cfg_link_up = link_v;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic pulse_inject(input logic [10:0] off);
        cfg_err_offset = off;
        @(negedge clk);
        cfg_err_inject = 1'b1;
        @(negedge clk);
        cfg_err_inject = 1'b0;
    endtask

    task automatic send_frame(input int npre, input int nd, input int er_at,
                              input int link_at, input int inj_at,
                              input bit drop, input int ifg);
        for (int j = 0; j < npre + 1 + nd; j++) begin
            logic [7:0] b;
            logic       ber, lk_down, hit;
            int         i;
            exp_t       x;
            i = j - npre - 1;
            if (j < npre) b = 8'h55;
            else if (j == npre) b = 8'hD5;
            else b = 8'($urandom_range(0, 255));
            ber     = (er_at >= 0) && (i == er_at);
            lk_down = (link_at >= 0) && (i >= link_at);
            hit     = (inj_at >= 0) && (i == inj_at);
            if (!drop) link_v = !lk_down;
            drive(1'b1, b, ber);
            if (!drop) begin
                for (int k = 0; k < 3; k++) begin
                    if (!(j < npre && j < trim_of(k))) begin
                        x.cyc = cyc + lat_of(k);
                        x.er  = ber | lk_down | hit;
                        x.d   = b ^ {7'b0, hit};
                        sbq[k].push_back(x);
                    end
                end
            end
        end
        idle(ifg);
        link_v = 1'b1;
        if (!drop) begin
            exp_frames++;
            exp_bytes += nd;
            if (er_at >= 0) exp_txer++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            vec++;
            if (dv[k] !== 1'b0 || rxd[k] !== 8'h00 || rer[k] !== 1'b0 ||
                inj[k] !== 1'b0 || drp[k] !== 1'b0) begin
                errs++;
                $display("FAIL reset_out dut%0d: got dv=%b d=%h er=%b inj=%b drop=%b, want all 0",
                         k, dv[k], rxd[k], rer[k], inj[k], drp[k]);
            end
        end
        vec++;
        if (fc_a !== 0 || bc_a !== 0 || ec_a !== 0 || fc_c !== 0 || bc_c !== 0) begin
            errs++;
            $display("FAIL reset_cnt: got %0d %0d %0d %0d %0d, want 0",
                     fc_a, bc_a, ec_a, fc_c, bc_c);
        end
        rst_n = 1'b1;
        mon_en = 1'b1;
        idle(2);
    endtask

    task automatic test_basic;
        send_frame(7, 56, -1, -1, -1, 1'b0, 12);
        idle(6);
        vec++;
        if (fc_a !== 32'd1 || bc_a !== 32'd56) begin
            errs++;
            $display("FAIL basic_cnt: got frames %0d bytes %0d, want 1 56", fc_a, bc_a);
        end
        for (int k = 0; k < 3; k++) begin
            vec++;
            if (sbq[k].size() != 0) begin
                errs++;
                $display("FAIL basic_drain dut%0d: got %0d pending, want 0", k, sbq[k].size());
            end
        end
    endtask

    task automatic test_trim;
        int d0 [3];
        for (int k = 0; k < 3; k++) d0[k] = dv_cnt[k];
        send_frame(7, 56, -1, -1, -1, 1'b0, 12);
        idle(6);
        for (int k = 0; k < 3; k++) begin
            vec++;
            if (dv_cnt[k] - d0[k] != 64 - trim_of(k)) begin
                errs++;
                $display("FAIL trim_dv dut%0d: got %0d cycles, want %0d",
                         k, dv_cnt[k] - d0[k], 64 - trim_of(k));
            end
        end
        vec++;
        if (fc_b !== 32'd2 || bc_b !== 32'd112) begin
            errs++;
            $display("FAIL trim_cnt: got %0d %0d, want 2 112", fc_b, bc_b);
        end
    endtask

    task automatic test_inject;
        int i0 [3];
        for (int k = 0; k < 3; k++) i0[k] = inj_seen[k];
        pulse_inject(11'd10);
        send_frame(7, 56, -1, -1, 10, 1'b0, 4);
        send_frame(7, 56, -1, -1, -1, 1'b0, 8);
        idle(4);
        for (int k = 0; k < 3; k++) begin
            vec++;
            if (inj_seen[k] - i0[k] != 1) begin
                errs++;
                $display("FAIL inj_once dut%0d: got %0d pulses, want 1", k, inj_seen[k] - i0[k]);
            end
        end
        pulse_inject(11'd40);
        send_frame(7, 20, -1, -1, -1, 1'b0, 4);
        send_frame(7, 56, -1, -1, 40, 1'b0, 8);
        idle(4);
        for (int k = 0; k < 3; k++) begin
            vec++;
            if (inj_seen[k] - i0[k] != 2) begin
                errs++;
                $display("FAIL inj_carry dut%0d: got %0d pulses, want 2", k, inj_seen[k] - i0[k]);
            end
        end
    endtask

    task automatic test_link_down_start;
        int p0 [3];
        int v0 [3];
        for (int k = 0; k < 3; k++) begin
            p0[k] = drop_seen[k];
            v0[k] = dv_cnt[k];
        end
        link_v = 1'b0;
        send_frame(7, 30, -1, -1, -1, 1'b1, 4);
        idle(8);
        for (int k = 0; k < 3; k++) begin
            vec++;
            if (drop_seen[k] - p0[k] != 1 || dv_cnt[k] != v0[k]) begin
                errs++;
                $display("FAIL drop dut%0d: got %0d pulses %0d dv, want 1 0",
                         k, drop_seen[k] - p0[k], dv_cnt[k] - v0[k]);
            end
        end
        vec++;
        if (fc_a !== 32'(exp_frames) || bc_a !== 32'(exp_bytes)) begin
            errs++;
            $display("FAIL drop_cnt: got %0d %0d, want %0d %0d", fc_a, bc_a, exp_frames, exp_bytes);
        end
    endtask

    task automatic test_link_loss;
        send_frame(7, 40, -1, 20, -1, 1'b0, 4);
        idle(8);
        vec++;
        if (fc_a !== 32'(exp_frames) || bc_a !== 32'(exp_bytes)) begin
            errs++;
            $display("FAIL loss_cnt: got %0d %0d, want %0d %0d", fc_a, bc_a, exp_frames, exp_bytes);
        end
    endtask

    task automatic test_back_to_back;
        send_frame(7, 30, -1, -1, -1, 1'b0, 1);
        send_frame(7, 30, 5, -1, -1, 1'b0, 1);
        idle(10);
        vec++;
        if (ec_a !== 32'd1 || fc_a !== 32'(exp_frames)) begin
            errs++;
            $display("FAIL b2b_cnt: got txer %0d frames %0d, want 1 %0d", ec_a, fc_a, exp_frames);
        end
        for (int k = 0; k < 3; k++) begin
            vec++;
            if (sbq[k].size() != 0) begin
                errs++;
                $display("FAIL b2b_drain dut%0d: got %0d pending, want 0", k, sbq[k].size());
            end
        end
    endtask

    task automatic test_saturation;
        for (int n = 0; n < 8; n++) send_frame(7, 4, -1, -1, -1, 1'b0, 2);
        idle(8);
        vec++;
        if (fc_c !== 4'(sat15(exp_frames)) || bc_c !== 4'(sat15(exp_bytes)) ||
            ec_c !== 4'(sat15(exp_txer))) begin
            errs++;
            $display("FAIL sat_c: got %0d %0d %0d, want %0d %0d %0d", fc_c, bc_c, ec_c,
                     sat15(exp_frames), sat15(exp_bytes), sat15(exp_txer));
        end
        vec++;
        if (fc_a !== 32'(exp_frames) || bc_a !== 32'(exp_bytes) || fc_b !== 32'(exp_frames)) begin
            errs++;
            $display("FAIL sat_wide: got %0d %0d %0d, want %0d %0d", fc_a, bc_a, fc_b,
                     exp_frames, exp_bytes);
        end
    endtask

    task automatic test_reset_midframe;
        mon_en = 1'b0;
        for (int k = 0; k < 3; k++) sbq[k].delete();
        for (int j = 0; j < 12; j++) drive(1'b1, (j < 7) ? 8'h55 : ((j == 7) ? 8'hD5 : 8'hA5), 1'b0);
        vec++;
        if (dv[0] !== 1'b1) begin
            errs++;
            $display("FAIL mid_active: got dv=%b, want 1", dv[0]);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            vec++;
            if (dv[k] !== 1'b0 || rxd[k] !== 8'h00 || rer[k] !== 1'b0) begin
                errs++;
                $display("FAIL mid_reset dut%0d: got dv=%b d=%h er=%b, want 0",
                         k, dv[k], rxd[k], rer[k]);
            end
        end
        vec++;
        if (fc_a !== 0 || bc_a !== 0 || fc_c !== 0) begin
            errs++;
            $display("FAIL mid_reset_cnt: got %0d %0d %0d, want 0", fc_a, bc_a, fc_c);
        end
        idle(2);
        rst_n = 1'b1;
        idle(2);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_trim();
        test_inject();
        test_link_down_start();
        test_link_loss();
        test_back_to_back();
        test_saturation();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
